// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   - arb_state_t : arbiter FSM states (IDLE arbitrates, ACCESS drives memory)
//   - port_id_t   : identifies requester port 0 or 1
//   - OP_SIZE_*   : access size/sign codes understood by the data memory;
//                   the arbiter passes them through untouched
//   - other_port  : returns the opposite requester id
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef logic port_id_t;

  localparam logic [2:0] OP_SIZE_B  = 3'b000;
  localparam logic [2:0] OP_SIZE_H  = 3'b001;
  localparam logic [2:0] OP_SIZE_W  = 3'b010;
  localparam logic [2:0] OP_SIZE_BU = 3'b100;
  localparam logic [2:0] OP_SIZE_HU = 3'b101;

  function automatic port_id_t other_port(input port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational requester selection for dmem_arbiter.
// Ports:
//   p0_valid, p1_valid  : request present on each port
//   lock_active         : a port currently owns the memory
//   lock_owner          : id of the owning port (meaningful when lock_active)
//   last_grant          : id of the most recently accepted port
//   pick_valid          : a port is selected this cycle
//   pick_port           : id of the selected port
// Configuration macro: DMEM_ARB_RR_EN -- when defined a tie goes to the port
// that was not granted last; otherwise port 0 always wins a tie.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic     p0_valid,
  input  logic     p1_valid,
  input  logic     lock_active,
  input  port_id_t lock_owner,
  input  port_id_t last_grant,
  output logic     pick_valid,
  output port_id_t pick_port
);

`ifndef DMEM_ARB_RR_EN
  // Fixed priority keeps last_grant around only for the round-robin build.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // A lock owner excludes the other port entirely, even if the owner is
  // momentarily idle; otherwise a lone requester wins and ties are resolved
  // by the configured policy.
  always_comb begin
    pick_valid = 1'b0;
    pick_port  = 1'b0;
    if (lock_active) begin
      pick_port  = lock_owner;
      pick_valid = lock_owner ? p1_valid : p0_valid;
    end else if (p0_valid && p1_valid) begin
      pick_valid = 1'b1;
`ifdef DMEM_ARB_RR_EN
      pick_port  = other_port(last_grant);
`else
      pick_port  = 1'b0;
`endif
    end else if (p0_valid) begin
      pick_valid = 1'b1;
      pick_port  = 1'b0;
    end else if (p1_valid) begin
      pick_valid = 1'b1;
      pick_port  = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-cycle data memory.
// A request accepted in cycle N drives memory in cycle N+1 and returns its
// response pulse in cycle N+2, giving at most one transfer every 2 cycles.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   pN_valid/pN_ready             : request handshake for port N (0,1)
//   pN_we, pN_op_size, pN_a, pN_wd: request command fields
//   pN_lock                       : keep the grant after this transfer
//   pN_rvalid, pN_rd              : one-cycle response pulse and held data
//   mem_a, mem_we, mem_op_size,
//   mem_wd, mem_rd                : memory port (mem_rd is combinational)
// Parameters: ADDR_W, DATA_W, LOCK_MAX (max consecutive locked transfers).
// Configuration macro: DMEM_ARB_RR_EN -- round-robin tie breaking
// (see dmem_arb_pick); default build gives port 0 priority on ties.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [2:0]        p0_op_size,
  input  logic [ADDR_W-1:0] p0_a,
  input  logic [DATA_W-1:0] p0_wd,
  input  logic              p0_lock,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rd,

  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [2:0]        p1_op_size,
  input  logic [ADDR_W-1:0] p1_a,
  input  logic [DATA_W-1:0] p1_wd,
  input  logic              p1_lock,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rd,

  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [2:0]        mem_op_size,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t        state, state_next;

  logic [ADDR_W-1:0] cmd_a;
  logic              cmd_we;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_wd;
  port_id_t          cmd_port;

  logic              lock_active;
  port_id_t          lock_owner;
  logic [CNT_W-1:0]  lock_cnt;
  port_id_t          last_grant;

  logic              pick_valid;
  port_id_t          pick_port;
  logic              accept;

  logic              req_we;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_a;
  logic [DATA_W-1:0] req_wd;
  logic              req_lock;

  logic [CNT_W-1:0]  cnt_inc;
  logic              keep_lock;

  dmem_arb_pick u_pick (
    .p0_valid    (p0_valid),
    .p1_valid    (p1_valid),
    .lock_active (lock_active),
    .lock_owner  (lock_owner),
    .last_grant  (last_grant),
    .pick_valid  (pick_valid),
    .pick_port   (pick_port)
  );

  assign req_we   = pick_port ? p1_we      : p0_we;
  assign req_op   = pick_port ? p1_op_size : p0_op_size;
  assign req_a    = pick_port ? p1_a       : p0_a;
  assign req_wd   = pick_port ? p1_wd      : p0_wd;
  assign req_lock = pick_port ? p1_lock    : p0_lock;

  // The lock-setting transfer itself counts as the owner's first, so the
  // owner gets at most LOCK_MAX back-to-back grants before being released.
  assign cnt_inc   = (lock_active ? lock_cnt : '0) + CNT_W'(1);
  assign keep_lock = req_lock && (cnt_inc != CNT_W'(LOCK_MAX));

  // Memory address/size/data are driven straight from the command registers,
  // so they naturally hold their last values while idle.
  assign mem_a       = cmd_a;
  assign mem_op_size = cmd_op;
  assign mem_wd      = cmd_wd;

  // Handshake and write strobe are gated by rst so that nothing is accepted
  // or written in a reset cycle, including one that lands on ACCESS.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    p0_ready   = 1'b0;
    p1_ready   = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid && !rst) begin
          accept     = 1'b1;
          p0_ready   = (pick_port == 1'b0);
          p1_ready   = (pick_port == 1'b1);
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_we     = cmd_we && !rst;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_a    <= '0;
      cmd_we   <= 1'b0;
      cmd_op   <= '0;
      cmd_wd   <= '0;
      cmd_port <= 1'b0;
    end else if (accept) begin
      cmd_a    <= req_a;
      cmd_we   <= req_we;
      cmd_op   <= req_op;
      cmd_wd   <= req_wd;
      cmd_port <= pick_port;
    end
  end

  // Writes return zero data; pN_rd otherwise keeps its value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rd     <= '0;
      p1_rd     <= '0;
    end else begin
      p0_rvalid <= (state == ACCESS) && (cmd_port == 1'b0);
      p1_rvalid <= (state == ACCESS) && (cmd_port == 1'b1);
      if ((state == ACCESS) && (cmd_port == 1'b0))
        p0_rd <= cmd_we ? '0 : mem_rd;
      if ((state == ACCESS) && (cmd_port == 1'b1))
        p1_rd <= cmd_we ? '0 : mem_rd;
    end
  end

  // Only the owner can be accepted while locked, so every locked acceptance
  // is an owner transfer that advances the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      lock_cnt    <= '0;
      last_grant  <= 1'b1;
    end else if (accept) begin
      last_grant <= pick_port;
      if (keep_lock) begin
        lock_active <= 1'b1;
        lock_owner  <= pick_port;
        lock_cnt    <= cnt_inc;
      end else begin
        lock_active <= 1'b0;
        lock_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. Expected grants and response data
// are queued by the stimulus; a negedge monitor pops and compares them.
// Honors DMEM_ARB_RR_EN for the expected tie-break order.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              p0_valid, p0_ready, p0_we, p0_lock, p0_rvalid;
  logic [2:0]        p0_op_size;
  logic [ADDR_W-1:0] p0_a;
  logic [DATA_W-1:0] p0_wd, p0_rd;
  logic              p1_valid, p1_ready, p1_we, p1_lock, p1_rvalid;
  logic [2:0]        p1_op_size;
  logic [ADDR_W-1:0] p1_a;
  logic [DATA_W-1:0] p1_wd, p1_rd;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic [2:0]        mem_op_size;
  logic [DATA_W-1:0] mem_wd, mem_rd;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_op_size(p0_op_size),
    .p0_a(p0_a), .p0_wd(p0_wd), .p0_lock(p0_lock), .p0_rvalid(p0_rvalid), .p0_rd(p0_rd),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_op_size(p1_op_size),
    .p1_a(p1_a), .p1_wd(p1_wd), .p1_lock(p1_lock), .p1_rvalid(p1_rvalid), .p1_rd(p1_rd),
    .mem_a(mem_a), .mem_we(mem_we), .mem_op_size(mem_op_size), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory preloaded so an unwritten word at byte address a reads 0xC0DE0000|a.
  logic [31:0] mem [0:63];
  assign mem_rd = mem[mem_a[7:2]];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 | (i << 2);
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  port_id_t    exp_grant [$];
  logic [31:0] exp_rd0 [$];
  logic [31:0] exp_rd1 [$];
  int          rv_cyc0 [$];
  int          rv_cyc1 [$];
  int          acc_cnt0 = 0;
  int          acc_cnt1 = 0;

  logic        exp_acc = 1'b0;
  logic        exp_we  = 1'b0;
  logic [31:0] exp_a, exp_wd;
  logic [2:0]  exp_op;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic logAccept(input port_id_t p, input logic we, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd);
    if (exp_grant.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL grant_order: got grant to port %0d, expected no grant", p);
    end else begin
      checkOutput("grant_order", {31'b0, p}, {31'b0, exp_grant.pop_front()});
    end
    if (p == 1'b0) begin acc_cnt0++; rv_cyc0.push_back(cyc + 2); end
    else           begin acc_cnt1++; rv_cyc1.push_back(cyc + 2); end
    exp_acc = 1'b1;
    exp_we  = we;
    exp_op  = op;
    exp_a   = a;
    exp_wd  = wd;
  endtask

  // Monitor: checks the memory cycle following each acceptance, response
  // data and latency, and logs grants in order.
  always @(negedge clk) begin
    if (rst) begin
      rv_cyc0.delete();
      rv_cyc1.delete();
      exp_acc = 1'b0;
    end else begin
      if (exp_acc || mem_we) begin
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, exp_acc && exp_we});
        if (exp_acc) begin
          checkOutput("mem_a", mem_a, exp_a);
          checkOutput("mem_wd", mem_wd, exp_wd);
          checkOutput("mem_op_size", {29'b0, mem_op_size}, {29'b0, exp_op});
        end
      end
      exp_acc = 1'b0;
      if (p0_ready && p1_ready) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL ready_onehot: got both ready, expected at most one");
      end
      if (p0_rvalid) begin
        if (exp_rd0.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL p0_rvalid: got pulse, expected none (cycle %0d)", cyc);
        end else checkOutput("p0_rd", p0_rd, exp_rd0.pop_front());
        if (rv_cyc0.size() != 0) checkOutput("p0_rvalid_cycle", cyc, rv_cyc0.pop_front());
      end
      if (p1_rvalid) begin
        if (exp_rd1.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL p1_rvalid: got pulse, expected none (cycle %0d)", cyc);
        end else checkOutput("p1_rd", p1_rd, exp_rd1.pop_front());
        if (rv_cyc1.size() != 0) checkOutput("p1_rvalid_cycle", cyc, rv_cyc1.pop_front());
      end
      if (p0_valid && p0_ready) logAccept(1'b0, p0_we, p0_op_size, p0_a, p0_wd);
      if (p1_valid && p1_ready) logAccept(1'b1, p1_we, p1_op_size, p1_a, p1_wd);
    end
  end

  task automatic dropValid(input int port);
    if (port == 0) begin p0_valid = 1'b0; p0_lock = 1'b0; end
    else           begin p1_valid = 1'b0; p1_lock = 1'b0; end
  endtask

  // Presents one request and returns just after the edge that accepts it.
  // The request stays on the port until the caller replaces or drops it.
  task automatic applyStimulus(input int port, input logic we, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] wd, input logic lock,
                               input logic [31:0] exp_rd, input bit expect_resp);
    int waited = 0;
    if (port == 0) begin
      p0_valid = 1'b1; p0_we = we; p0_op_size = op; p0_a = a; p0_wd = wd; p0_lock = lock;
    end else begin
      p1_valid = 1'b1; p1_we = we; p1_op_size = op; p1_a = a; p1_wd = wd; p1_lock = lock;
    end
    forever begin
      @(negedge clk);
      if ((port == 0) ? p0_ready : p1_ready) break;
      waited++;
      if (waited > 200) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL grant_timeout: port %0d got no grant in %0d cycles, expected a grant", port, waited);
        dropValid(port);
        return;
      end
    end
    if (expect_resp) begin
      if (port == 0) exp_rd0.push_back(exp_rd);
      else           exp_rd1.push_back(exp_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitAccepts(input int port, input int target);
    int guard = 0;
    while (((port == 0) ? acc_cnt0 : acc_cnt1) < target && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_wait: port %0d accepts stuck, expected %0d", port, target);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_p0_ready"}, {31'b0, p0_ready}, 32'h0);
    checkOutput({tag, "_p1_ready"}, {31'b0, p1_ready}, 32'h0);
    checkOutput({tag, "_p0_rvalid"}, {31'b0, p0_rvalid}, 32'h0);
    checkOutput({tag, "_p1_rvalid"}, {31'b0, p1_rvalid}, 32'h0);
    checkOutput({tag, "_p0_rd"}, p0_rd, 32'h0);
    checkOutput({tag, "_p1_rd"}, p1_rd, 32'h0);
    checkOutput({tag, "_mem_a"}, mem_a, 32'h0);
    checkOutput({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
    checkOutput({tag, "_mem_wd"}, mem_wd, 32'h0);
    checkOutput({tag, "_mem_op_size"}, {29'b0, mem_op_size}, 32'h0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base0, base1;
    rst = 1'b1;
    p0_valid = 1'b0; p0_we = 1'b0; p0_op_size = 3'b0; p0_a = '0; p0_wd = '0; p0_lock = 1'b0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_op_size = 3'b0; p1_a = '0; p1_wd = '0; p1_lock = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Both ports valid continuously; last-granted is 1 out of reset.
`ifdef DMEM_ARB_RR_EN
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
    fork
      begin
        applyStimulus(0, 1'b0, OP_SIZE_W, 32'h40, 32'h0, 1'b0, 32'hC0DE0040, 1'b1);
        applyStimulus(0, 1'b0, OP_SIZE_W, 32'h44, 32'h0, 1'b0, 32'hC0DE0044, 1'b1);
        applyStimulus(0, 1'b0, OP_SIZE_W, 32'h48, 32'h0, 1'b0, 32'hC0DE0048, 1'b1);
        applyStimulus(0, 1'b0, OP_SIZE_W, 32'h4C, 32'h0, 1'b0, 32'hC0DE004C, 1'b1);
        dropValid(0);
      end
      begin
        applyStimulus(1, 1'b0, OP_SIZE_W, 32'h80, 32'h0, 1'b0, 32'hC0DE0080, 1'b1);
        applyStimulus(1, 1'b0, OP_SIZE_W, 32'h84, 32'h0, 1'b0, 32'hC0DE0084, 1'b1);
        dropValid(1);
      end
    join
    idleCycles(3);

    // p0 alone: word write then read back at 0x10.
    exp_grant = '{1'b0, 1'b0};
    applyStimulus(0, 1'b1, OP_SIZE_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, OP_SIZE_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    dropValid(0);
    idleCycles(4);
    @(negedge clk);
    checkOutput("p0_rd_hold", p0_rd, 32'hDEADBEEF);
    idleCycles(1);

    // p1 locks for three transfers and releases on the fourth; p0 waits.
    // p0's read of 0x58 must observe p1's final write.
    exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    base1 = acc_cnt1;
    fork
      begin
        applyStimulus(1, 1'b1, OP_SIZE_H, 32'h50, 32'h11111111, 1'b1, 32'h0, 1'b1);
        applyStimulus(1, 1'b0, OP_SIZE_W, 32'h50, 32'h0, 1'b1, 32'h11111111, 1'b1);
        applyStimulus(1, 1'b0, OP_SIZE_BU, 32'h54, 32'h0, 1'b1, 32'hC0DE0054, 1'b1);
        applyStimulus(1, 1'b1, OP_SIZE_W, 32'h58, 32'h22222222, 1'b0, 32'h0, 1'b1);
        dropValid(1);
      end
      begin
        waitAccepts(1, base1 + 1);
        applyStimulus(0, 1'b0, OP_SIZE_BU, 32'h58, 32'h0, 1'b0, 32'h22222222, 1'b1);
        dropValid(0);
      end
    join
    idleCycles(3);

    // p0 holds lock=1 for eight transfers; the lock expires on the eighth.
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    base0 = acc_cnt0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(0, 1'b0, OP_SIZE_W, 32'h60 + 32'(i * 4), 32'h0, 1'b1,
                        32'hC0DE0060 + 32'(i * 4), 1'b1);
        dropValid(0);
      end
      begin
        waitAccepts(0, base0 + 1);
        applyStimulus(1, 1'b0, OP_SIZE_W, 32'h90, 32'h0, 1'b0, 32'hC0DE0090, 1'b1);
        dropValid(1);
      end
    join
    idleCycles(3);

    // Reset lands on the ACCESS cycle of a read at 0x20: no response at all.
    exp_grant = '{1'b0};
    applyStimulus(0, 1'b0, OP_SIZE_W, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    dropValid(0);
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("post_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    idleCycles(3);

    // Arbiter is back in IDLE and serving requests.
    exp_grant = '{1'b0};
    applyStimulus(0, 1'b0, OP_SIZE_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    dropValid(0);
    idleCycles(5);

    checkOutput("grants_left", exp_grant.size(), 32'h0);
    checkOutput("p0_resp_left", exp_rd0.size(), 32'h0);
    checkOutput("p1_resp_left", exp_rd1.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of requests and the memory port.
REQ-002 Parameter: DATA_W, 32, write-data and read-data width.
REQ-003 Parameter: LOCK_MAX, 8, maximum consecutive accepted transfers one locked owner may issue.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port group, N in {0,1}:
  - pN_valid  input  1  request present.
  - pN_ready  output  1  request accepted this cycle when pN_valid is also high.
  - pN_we  input  1  write request.
  - pN_op_size  input  3  access size/sign code, passed through unchanged.
  - pN_a  input  ADDR_W  byte address.
  - pN_wd  input  DATA_W  write data.
  - pN_lock  input  1  keep the grant after this transfer.
  - pN_rvalid  output  1  response pulse.
  - pN_rd  output  DATA_W  response data.
REQ-007 Memory side ports:
  - mem_a  output  ADDR_W  address.
  - mem_we  output  1  write enable.
  - mem_op_size  output  3  size/sign code.
  - mem_wd  output  DATA_W  write data.
  - mem_rd  input  DATA_W  combinational read data for mem_a.

Function
REQ-008 The FSM SHALL have two states: IDLE (arbitrate) and ACCESS (memory driven).
REQ-009 In IDLE, at most one pN_ready SHALL be high: the one for the selected port. pN_ready SHALL be low in ACCESS.
REQ-010 Selection, lock owner present: only the owner SHALL be eligible; the other port SHALL wait even if valid.
REQ-011 Selection, no lock owner, exactly one port valid: that port SHALL be selected.
REQ-012 Selection, no lock owner, both ports valid: selection SHALL follow REQ-025/REQ-026.
REQ-013 On acceptance, the arbiter SHALL latch a, we, op_size, wd and the port id into command registers and enter ACCESS next cycle.
REQ-014 In ACCESS, mem_a, mem_op_size and mem_wd SHALL come from the command registers. mem_we SHALL equal the latched we for exactly that one cycle.
REQ-015 In ACCESS, mem_rd SHALL be captured; the FSM SHALL then return to IDLE.
REQ-016 In the cycle after ACCESS, the latched port's pN_rvalid SHALL be high for exactly one cycle.
  - pN_rd SHALL carry the captured mem_rd for reads and 0 for writes.
  - The other port's rvalid SHALL stay low.
REQ-017 Timing: accept cycle N -> memory cycle N+1 -> rvalid cycle N+2. Peak throughput SHALL be one transfer per 2 cycles.
REQ-018 In IDLE, mem_we SHALL be 0, and mem_a, mem_op_size and mem_wd SHALL hold their last values.
REQ-019 Lock set: an accepted transfer with pN_lock=1 SHALL make N the owner.
REQ-020 Lock release: an owner's accepted transfer with pN_lock=0 SHALL clear ownership after that transfer.
REQ-021 Lock counter: a counter SHALL count the owner's accepted transfers. When it reaches LOCK_MAX, ownership SHALL be forcibly cleared and the counter zeroed, even if pN_lock=1.
REQ-022 pN_rd SHALL hold its value between rvalid pulses.

Reset
REQ-023 Reset SHALL force the following, taking priority over acceptance and any in-flight ACCESS:
  - FSM to IDLE.
  - Both ready and rvalid outputs low.
  - mem_we=0.
  - mem_a, mem_wd, mem_op_size, command registers and pN_rd to 0.
  - No lock owner, lock counter 0.
  - last-granted register = 1.
REQ-024 A transfer accepted in the reset cycle, or in ACCESS during reset, SHALL produce no mem_we and no rvalid.

Configuration
REQ-025 With DMEM_ARB_RR_EN defined, a both-valid tie SHALL go to the port not in last-granted. last-granted SHALL update on every acceptance.
REQ-026 Without DMEM_ARB_RR_EN, port 0 SHALL always win a tie. last-granted SHALL still exist but not affect selection.

Structure
REQ-027 Package dmem_arb_pkg SHALL hold:
  - the FSM state enum.
  - the port-id typedef.
  - the op_size code constants shared with the data memory.
REQ-028 The tie/lock selection logic SHALL be one combinational sub-module, dmem_arb_pick.

Verification
REQ-029 p0 alone writes a=0x10, wd=0xDEADBEEF, op_size=010, then reads a=0x10:
  - Write: mem_we high exactly one cycle after acceptance; p0_rvalid two cycles after, with p0_rd=0.
  - Read: p0_rd=0xDEADBEEF two cycles after acceptance.
REQ-030 Both ports valid continuously:
  - With DMEM_ARB_RR_EN: grants alternate 0,1,0,1.
  - Without it: p0 is granted every time; p1 is starved.
REQ-031 p1 issues 3 transfers with lock=1, then lock=0, while p0 stays valid: p0 receives no grant until after the p1 lock=0 transfer.
REQ-032 LOCK_MAX=8, p0 keeps lock=1 with p1 valid: p1 is granted after p0's 8th accepted transfer.
REQ-033 rst asserted during the ACCESS cycle of a read at 0x20: no rvalid on either port; next cycle all outputs are 0 and FSM is IDLE.
